// File: rtl/xbar_pkg.sv
// Shared XBar definitions: AXI response codes and a
// constant log2 helper used to size queue pointers.
package xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/b_resp_gen_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a
// registered full flag; push on full is accepted only with pop.
module sync_fifo
  import xbar_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        full,
  output logic                        empty,
  output logic [clog2(DEPTH):0]       count
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign cnt_nxt = count + PW'(do_push) - PW'(do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer advance and full flag derived from next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      full <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      full <= (cnt_nxt == PW'(DEPTH));
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/b_resp_gen.sv
// Pairs accepted AW IDs with W burst completions and issues one
// B response per burst. Option: B_RESP_GEN_EXOKAY_EN (AWLOCK).
module b_resp_gen
  import xbar_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_fire,
  input  logic [ID_WIDTH-1:0] AWID,
`ifdef B_RESP_GEN_EXOKAY_EN
  input  logic                AWLOCK,
`endif
  output logic                aw_full,
  input  logic                w_last_fire,
  input  logic                w_err,
  output logic                w_full,
  output logic [ID_WIDTH-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

`ifdef B_RESP_GEN_EXOKAY_EN
  localparam int EW = ID_WIDTH + 1;
`else
  localparam int EW = ID_WIDTH;
`endif
  localparam int CW = clog2(DEPTH) + 1;

  logic [EW-1:0] aw_din;
  logic [EW-1:0] aw_dout;
  logic          aw_empty;
  logic [CW-1:0] aw_count;
  logic [0:0]    w_dout;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          aw_lock;
  logic          pair;
  logic [1:0]    resp_nxt;

`ifdef B_RESP_GEN_EXOKAY_EN
  assign aw_din  = {AWLOCK, AWID};
  assign aw_lock = aw_dout[ID_WIDTH];
`else
  assign aw_din  = AWID;
  assign aw_lock = 1'b0;
`endif

  sync_fifo #(
    .DATA_WIDTH(EW),
    .DEPTH     (DEPTH)
  ) u_aw_q (
    .clk  (clk),
    .rst  (rst),
    .push (aw_fire),
    .pop  (pair),
    .din  (aw_din),
    .dout (aw_dout),
    .full (aw_full),
    .empty(aw_empty),
    .count(aw_count)
  );

  sync_fifo #(
    .DATA_WIDTH(1),
    .DEPTH     (DEPTH)
  ) u_w_q (
    .clk  (clk),
    .rst  (rst),
    .push (w_last_fire),
    .pop  (pair),
    .din  (w_err),
    .dout (w_dout),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

  assign pair = ~aw_empty & ~w_empty & (~BVALID | BREADY);

  // Response code for the pair at the queue heads.
  always_comb begin
    resp_nxt = RESP_OKAY;
    unique case (1'b1)
      w_dout[0]:              resp_nxt = RESP_SLVERR;
      (~w_dout[0] & aw_lock): resp_nxt = RESP_EXOKAY;
      default:                resp_nxt = RESP_OKAY;
    endcase
  end

  // Output register: load on pairing, clear after handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BVALID <= 1'b0;
      BID    <= '0;
      BRESP  <= RESP_OKAY;
    end else if (pair) begin
      BVALID <= 1'b1;
      BID    <= aw_dout[ID_WIDTH-1:0];
      BRESP  <= resp_nxt;
    end else if (BREADY) begin
      BVALID <= 1'b0;
    end
  end

`ifdef B_RESP_GEN_EXOKAY_EN
  // Upstream must not push into a full queue.
  a_aw_ovf: assert property (@(posedge clk) disable iff (rst)
    !(aw_fire && aw_full && !pair));
  a_w_ovf: assert property (@(posedge clk) disable iff (rst)
    !(w_last_fire && w_full && !pair));
  a_cnt: assert property (@(posedge clk) disable iff (rst)
    (aw_count <= CW'(DEPTH)) && (w_count <= CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_b_resp_gen.sv
// Scoreboard bench for b_resp_gen: directed stimulus pushes
// expected responses, a negedge monitor checks each handshake.
module tb_b_resp_gen;

  localparam int IDW   = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           aw_fire = 1'b0;
  logic [IDW-1:0] AWID = '0;
  logic           awlock = 1'b0;
  logic           aw_full;
  logic           w_last_fire = 1'b0;
  logic           w_err = 1'b0;
  logic           w_full;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY = 1'b0;

  exp_t       sb[$];
  logic [4:0] aw_m[$];
  logic       w_m[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  b_resp_gen #(
    .ID_WIDTH(IDW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .aw_fire    (aw_fire),
    .AWID       (AWID),
`ifdef B_RESP_GEN_EXOKAY_EN
    .AWLOCK     (awlock),
`endif
    .aw_full    (aw_full),
    .w_last_fire(w_last_fire),
    .w_err      (w_err),
    .w_full     (w_full),
    .BID        (BID),
    .BRESP      (BRESP),
    .BVALID     (BVALID),
    .BREADY     (BREADY)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_pair();
    logic [4:0] a;
    logic       e;
    logic [1:0] r;
    while (aw_m.size() != 0 && w_m.size() != 0) begin
      a = aw_m.pop_front();
      e = w_m.pop_front();
      r = e ? 2'b10 : (a[4] ? 2'b01 : 2'b00);
      sb.push_back({a[3:0], r});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic aw, input logic [IDW-1:0] id,
                      input logic lk, input logic w, input logic err);
    aw_fire     = aw;
    AWID        = id;
    awlock      = lk;
    w_last_fire = w;
    w_err       = err;
    tick();
    aw_fire     = 1'b0;
    w_last_fire = 1'b0;
    if (aw) aw_m.push_back({lk, id});
    if (w) w_m.push_back(err);
    model_pair();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: every accepted response must match the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && BVALID && BREADY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id %0h resp %0h expected none",
                 BID, BRESP);
      end else begin
        e = sb.pop_front();
        chk("b_id", BID, e.id);
        chk("b_resp", BRESP, e.resp);
      end
    end
  end

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_aw_full", aw_full, 0);
    chk("rst_w_full", w_full, 0);
    tick();
    rst = 1'b0;
    BREADY = 1'b1;
    tick();

    // in-order basic
    step(1, 4'd3, 0, 0, 0);
    step(0, 4'd0, 0, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    @(negedge clk);
    chk("lat_basic_pre", BVALID, 0);
    tick();
    @(negedge clk);
    chk("lat_basic_on", BVALID, 1);
    tick();
    @(negedge clk);
    chk("lat_basic_off", BVALID, 0);

    // W completion before AW
    step(0, 4'd0, 0, 1, 1);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("w_first_wait", BVALID, 0);
    step(1, 4'd5, 0, 0, 0);
    @(negedge clk);
    chk("w_first_pre", BVALID, 0);
    tick();
    @(negedge clk);
    chk("w_first_on", BVALID, 1);
    tick();

    // backpressure and AW full
    BREADY = 1'b0;
    for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0, 0);
    @(negedge clk);
    chk("aw_full_set", aw_full, 1);
    aw_fire = 1'b1;
    AWID = 4'd9;
    tick();
    aw_fire = 1'b0;
    @(negedge clk);
    chk("aw_full_hold", aw_full, 1);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 1, 1);
    step(0, 4'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_bvalid", BVALID, 1);
      chk("hold_bid", BID, 1);
      chk("hold_bresp", BRESP, 0);
      tick();
    end
    BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", BVALID, 1);
      tick();
    end
    @(negedge clk);
    chk("b2b_done", BVALID, 0);
    chk("aw_full_clr", aw_full, 0);
    drain();

    // fill both queues, then push/pop at full
    BREADY = 1'b0;
    step(0, 4'd0, 0, 1, 1);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 1, 0);
    step(0, 4'd0, 0, 1, 1);
    @(negedge clk);
    chk("w_full_set", w_full, 1);
    step(1, 4'd6, 0, 0, 0);
    step(1, 4'd7, 0, 0, 0);
    step(1, 4'd8, 0, 0, 0);
    step(1, 4'd9, 0, 0, 0);
    step(1, 4'd10, 0, 1, 0);
    @(negedge clk);
    chk("both_full_aw", aw_full, 1);
    chk("both_full_w", w_full, 1);
    BREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1, 4'(i + 11), 0, 1, i[0]);
      @(negedge clk);
      chk("full_pp_aw", aw_full, 1);
      chk("full_pp_w", w_full, 1);
    end
    drain();
    tick();
    @(negedge clk);
    chk("wrap_aw_full", aw_full, 0);
    chk("wrap_w_full", w_full, 0);
    chk("wrap_idle", BVALID, 0);

`ifdef B_RESP_GEN_EXOKAY_EN
    // exclusive access responses
    step(1, 4'd7, 1, 0, 0);
    step(0, 4'd0, 0, 1, 0);
    step(1, 4'd2, 1, 1, 1);
    drain();
`endif

    // reset during a held response
    BREADY = 1'b0;
    step(1, 4'd2, 0, 1, 0);
    step(1, 4'd4, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_valid", BVALID, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", BVALID, 0);
    chk("mid_rst_bid", BID, 0);
    sb.delete();
    aw_m.delete();
    w_m.delete();
    #4;
    rst = 1'b0;
    BREADY = 1'b1;
    tick();
    step(0, 4'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", BVALID, 0);
      tick();
    end
    step(1, 4'd6, 0, 0, 0);
    drain();

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/b_resp_gen.md
Name: b_resp_gen

Overview:
- Slave-side write-response producer for the XBar. It is the B-channel source that feeds the B FIFO at a slave port.
- Pairs each accepted AW address (its ID) with the completion of the matching W burst (WLAST handshake plus error status). Issues one AXI B response per burst with a VALID/READY handshake.
- Sits between a slave's write-datapath core and the XBar's B return path. Single clock domain.

Parameters:
- ID_WIDTH, 4, width of AWID/BID.
- DEPTH, 4, max outstanding AW IDs and max outstanding completed-W records; power of two, minimum 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- aw_fire  input  1  AWVALID&AWREADY handshake seen this cycle.
- AWID  input  ID_WIDTH  ID of the accepted AW; sampled when aw_fire=1.
- aw_full  output  1  AW ID queue full; core must hold AWREADY low while 1.
- w_last_fire  input  1  WVALID&WREADY&WLAST handshake seen this cycle.
- w_err  input  1  burst had an error; sampled when w_last_fire=1.
- w_full  output  1  W record queue full; core must hold WREADY low on a last beat while 1.
- BID  output  ID_WIDTH  response ID.
- BRESP  output  2  response code.
- BVALID  output  1  response valid.
- BREADY  input  1  downstream accepts response.

Behaviour:
- Reset: asynchronous on rst=1. Both queues empty, BVALID=0, BID=0, BRESP=2'b00, aw_full=0, w_full=0. Reset mid-transaction discards all pending records and any held response. BVALID drops in the same cycle rst asserts.
- AW queue: DEPTH-entry FIFO of AWID. Pushes on aw_fire. If aw_fire occurs while aw_full=1, it is ignored (protocol violation). The simulation assertion for this is covered under the Optional Feature.
- W queue: DEPTH-entry FIFO of w_err. Pushes on w_last_fire. W completion may precede its AW; such records wait in the queue.
- Pairing: a pair is ready when both queues are non-empty and the output stage is free. The output stage is free when BVALID=0, or when BVALID=1 and BREADY=1.
- On a ready pair, both heads pop in the same cycle. Next cycle: BVALID=1, BID=AW head, BRESP=2'b10 (SLVERR) if the W head err=1, else 2'b00 (OKAY).
- Latency: if the second member of a pair is pushed at edge N, BVALID=1 after edge N+1. There is no bypass from push to output.
- Handshake: BID/BRESP/BVALID are registered and stay stable while BVALID=1 and BREADY=0.
- Back-to-back: with BREADY=1 held and queues non-empty, one response is issued per cycle (full throughput).
- Simultaneous push and pop on a full queue: allowed. Occupancy is unchanged; the full flag stays 1 and does not glitch.
- Full flags are registered from occupancy: aw_full=1 iff AW count==DEPTH, w_full=1 iff W count==DEPTH.
- Pointers are log2(DEPTH)+1 bits with natural wrap. The count is the difference of write and read pointers.
- Ordering: strictly in AW order; no ID-based reordering.

Optional Feature:
- Macro B_RESP_GEN_EXOKAY_EN.
- Defined:
  - Adds input AWLOCK (1 bit), sampled with AWID on aw_fire and stored in the AW queue (entry width ID_WIDTH+1).
  - Response for a locked burst with err=0 is BRESP=2'b01 (EXOKAY).
  - Locked with err=1 gives SLVERR.
  - Also enables simulation assertions: aw_fire while aw_full, and w_last_fire while w_full.
- Undefined: no AWLOCK port, BRESP is only OKAY or SLVERR, and no assertions.

Decomposition:
- Shared package xbar_pkg:
  - BRESP encodings RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Function clog2 for pointer width.
- One sub-module, sync_fifo (params DATA_WIDTH, DEPTH; ports clk, rst, push, pop, din, dout, full, empty, count). Instantiated twice: AW ID queue and W record queue.
- Pairing and output register live in b_resp_gen.

Test Plan:
- Reset state: rst=1 → BVALID=0, BID=0, BRESP=00, aw_full=0, w_full=0. Pulse rst during a held BVALID → BVALID=0 immediately; no response after release.
- In-order basic: AWID=3 at cycle 0, w_last_fire err=0 at cycle 2, BREADY=1 → BVALID=1 after edge 3 with BID=3, BRESP=00, for one cycle.
- W before AW: w_last_fire err=1 at cycle 0, AWID=5 at cycle 4 → BVALID after edge 5, BID=5, BRESP=10.
- Backpressure and full:
  - Push 4 AW (IDs 1,2,3,4) → aw_full=1.
  - Push 4 W with BREADY=0 → after pairing, the first response holds BID=1 stable; a fifth aw_fire while full is ignored.
  - Release BREADY → BIDs 1,2,3,4 on consecutive cycles.
- Simultaneous push/pop at full, with BREADY=1 and both queues full: aw_fire and w_last_fire each cycle for 10 cycles → aw_full stays 1, 10 responses in order, and pointers wrap without loss.
- With B_RESP_GEN_EXOKAY_EN: AWLOCK=1, AWID=7, err=0 → BRESP=01. AWLOCK=1, err=1 → BRESP=10.
